hdmi_period_scheduler: RTL

Runtime-configurable HDMI period scheduler. It replaces the fixed per-VIC timing and period logic in front of the TMDS channel encoders. It keeps the pixel position counters, optionally locks them to an external sync/DE stream, and classifies every pixel into one of five modes: control, video, video guard, data-island or island guard. It also emits preambles and a per-packet request strobe to the packet source, sizing each line's data island to the number of packets actually pending.

---
 rtl/hdmi_period_scheduler_pkg.sv | 32 +++
 rtl/hdmi_period_scheduler_if.sv | 24 ++
 rtl/hdmi_period_scheduler_sync_lock.sv | 68 ++++++
 rtl/hdmi_period_scheduler.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/hdmi_period_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Package  : hdmi_sched_pkg
// Brief    : Shared types and period lengths for hdmi_period_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package hdmi_sched_pkg;

    typedef enum logic [2:0] {
        CTRL   = 3'd0,
        VIDEO  = 3'd1,
        VGUARD = 3'd2,
        ISLAND = 3'd3,
        IGUARD = 3'd4
    } mode_t;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ARMED    = 2'd1,
        LOCKED   = 2'd2
    } lock_state_t;

    localparam int PREAMBLE_LEN    = 8;
    localparam int GUARD_LEN       = 2;
    localparam int PACKET_LEN      = 32;
    localparam int ISLAND_OVERHEAD = 36;

    localparam logic [3:0] c_ctrl_island_pre = 4'b0101;
    localparam logic [3:0] c_ctrl_video_pre  = 4'b0001;

endpackage
`default_nettype wire

// File: rtl/hdmi_period_scheduler_if.sv
`default_nettype none
// ============================================================================
// Interface : hdmi_period_scheduler_if
// Brief     : Packet-source handshake: pending count in, slot strobes out.
// Revision  : 1.0 - initial release
// ============================================================================
interface hdmi_period_scheduler_if;
    logic [4:0] pending_count;
    logic       packet_enable;
    logic       island_active;

    modport master (
        input  pending_count,
        output packet_enable,
        output island_active
    );

    modport slave (
        output pending_count,
        input  packet_enable,
        input  island_active
    );
endinterface
`default_nettype wire

// File: rtl/hdmi_period_scheduler_sync_lock.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_sync_lock
// Brief    : Aligns the pixel counters to an external DE stream and tracks lock.
// Revision : 1.0 - initial release
// ============================================================================
module hdmi_sync_lock
    import hdmi_sched_pkg::*;
#(
    parameter int BIT_WIDTH  = 12,
    parameter int BIT_HEIGHT = 11
) (
    input  wire                  clk_pixel,
    input  wire                  reset,
    input  wire                  sync_active,
    input  wire                  den_in,
    input  wire [BIT_WIDTH-1:0]  cx,
    input  wire [BIT_HEIGHT-1:0] cy,
    input  wire [BIT_WIDTH-1:0]  frame_width,
    input  wire [BIT_HEIGHT-1:0] screen_height,
    output logic                 reload,
    output logic                 locked
);

    lock_state_t r_state;
    logic        r_den_d;
    logic        r_miss;
    logic        w_rise;
    logic        w_aligned;

    assign w_rise    = den_in && !r_den_d;
    assign w_aligned = (cx == frame_width - BIT_WIDTH'(1));
    assign reload    = (r_state == ARMED) && w_rise;

    // A single misaligned DE edge is tolerated; the second in a row drops lock.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_state <= UNLOCKED;
            r_den_d <= 1'b0;
            r_miss  <= 1'b0;
            locked  <= 1'b0;
        end else begin
            r_den_d <= den_in;
            case (r_state)
                UNLOCKED: if (sync_active) r_state <= ARMED;
                ARMED: if (w_rise) begin
                    r_state <= LOCKED;
                    locked  <= 1'b1;
                    r_miss  <= 1'b0;
                end
                LOCKED: if (w_rise && (cy < screen_height)) begin
                    if (w_aligned) begin
                        r_miss <= 1'b0;
                    end else if (r_miss) begin
                        r_state <= UNLOCKED;
                        locked  <= 1'b0;
                        r_miss  <= 1'b0;
                    end else begin
                        r_miss <= 1'b1;
                    end
                end
                default: r_state <= UNLOCKED;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/hdmi_period_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_period_scheduler
// Brief    : Pixel counters and HDMI period classification with per-line island
//            sizing; define HDMI_SCHED_LOCK_EN to lock counters to external DE.
// Revision : 1.0 - initial release
// ============================================================================
module hdmi_period_scheduler
    import hdmi_sched_pkg::*;
#(
    parameter int BIT_WIDTH   = 12,
    parameter int BIT_HEIGHT  = 11,
    parameter int MAX_PACKETS = 18
) (
    input  wire                     clk_pixel,
    input  wire                     reset,
    input  wire  [BIT_WIDTH-1:0]    frame_width,
    input  wire  [BIT_WIDTH-1:0]    screen_width,
    input  wire  [BIT_HEIGHT-1:0]   frame_height,
    input  wire  [BIT_HEIGHT-1:0]   screen_height,
    input  wire                     sync_invert,
    input  wire                     hsync_in,
    input  wire                     vsync_in,
    input  wire                     den_in,
    input  wire                     hdmi_en,
    hdmi_period_scheduler_if.master pkt,
    output logic [BIT_WIDTH-1:0]    cx,
    output logic [BIT_HEIGHT-1:0]   cy,
    output logic [2:0]              mode,
    output logic [3:0]              ctrl,
    output logic                    hsync_out,
    output logic                    vsync_out,
    output logic                    locked
);

    // Two spare bits so x - S wraps far above any island offset when x < S.
    localparam int c_ew  = BIT_WIDTH + 2;
    localparam int c_isl = PREAMBLE_LEN + GUARD_LEN;

    logic [4:0]      r_n_max, r_n_line, w_n_max, w_n_line;
    logic [c_ew-1:0] w_spare, w_cap, w_x, w_fw, w_rel, w_len;
    logic            w_reload, w_island_on, w_vline;
    logic            w_in_pre, w_in_guard, w_in_island, w_in_vguard, w_in_vpre;
    mode_t           w_mode;
    logic [3:0]      w_ctrl;

    assign w_spare  = c_ew'(frame_width) - c_ew'(screen_width) - c_ew'(ISLAND_OVERHEAD);
    assign w_cap    = w_spare[c_ew-1] ? '0 : (w_spare >> $clog2(PACKET_LEN));
    assign w_n_max  = (w_cap > c_ew'(MAX_PACKETS)) ? 5'(MAX_PACKETS) : w_cap[4:0];
    assign w_n_line = (pkt.pending_count < r_n_max) ? pkt.pending_count : r_n_max;

    assign w_x   = c_ew'(cx);
    assign w_fw  = c_ew'(frame_width);
    assign w_rel = w_x - c_ew'(screen_width);
    assign w_len = c_ew'(r_n_line) << $clog2(PACKET_LEN);

    assign w_island_on = hdmi_en && (r_n_line != 5'd0);
    assign w_in_pre    = w_island_on && (w_rel < c_ew'(PREAMBLE_LEN));
    assign w_in_island = w_island_on && (w_rel >= c_ew'(c_isl)) && (w_rel < c_ew'(c_isl) + w_len);
    assign w_in_guard  = w_island_on &&
                         (((w_rel >= c_ew'(PREAMBLE_LEN)) && (w_rel < c_ew'(c_isl))) ||
                          ((w_rel >= c_ew'(c_isl) + w_len) && (w_rel < c_ew'(c_isl + GUARD_LEN) + w_len)));

    assign w_vline     = (cy < screen_height) || (cy == frame_height - BIT_HEIGHT'(1));
    assign w_in_vguard = hdmi_en && w_vline && (w_x + c_ew'(GUARD_LEN) >= w_fw);
    assign w_in_vpre   = hdmi_en && w_vline && (w_x + c_ew'(c_isl) >= w_fw) && !w_in_vguard;

    always_comb begin
        w_mode = den_in ? VIDEO : CTRL;
        w_ctrl = 4'b0000;
        if (w_in_guard)        w_mode = IGUARD;
        else if (w_in_island)  w_mode = ISLAND;
        else if (w_in_vguard)  w_mode = VGUARD;
        if (w_mode == CTRL) begin
            if (w_in_pre)       w_ctrl = c_ctrl_island_pre;
            else if (w_in_vpre) w_ctrl = c_ctrl_video_pre;
        end
    end

`ifdef HDMI_SCHED_LOCK_EN
    logic w_sync_active;
    assign w_sync_active = (hsync_in ^ sync_invert) && (vsync_in ^ sync_invert);

    hdmi_sync_lock #(
        .BIT_WIDTH  (BIT_WIDTH),
        .BIT_HEIGHT (BIT_HEIGHT)
    ) u_sync_lock (
        .clk_pixel     (clk_pixel),
        .reset         (reset),
        .sync_active   (w_sync_active),
        .den_in        (den_in),
        .cx            (cx),
        .cy            (cy),
        .frame_width   (frame_width),
        .screen_height (screen_height),
        .reload        (w_reload),
        .locked        (locked)
    );
`else
    logic w_unused_sync;
    assign w_unused_sync = sync_invert;
    assign w_reload      = 1'b0;
    assign locked        = 1'b1;
`endif

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            cx                <= '0;
            cy                <= '0;
            mode              <= CTRL;
            ctrl              <= 4'b0000;
            hsync_out         <= 1'b0;
            vsync_out         <= 1'b0;
            pkt.packet_enable <= 1'b0;
            pkt.island_active <= 1'b0;
            r_n_line          <= 5'd0;
            r_n_max           <= w_n_max;
        end else begin
            if (w_reload) begin
                cx <= '0;
                cy <= '0;
            end else if (cx == frame_width - BIT_WIDTH'(1)) begin
                cx <= '0;
                cy <= (cy == frame_height - BIT_HEIGHT'(1)) ? '0 : cy + BIT_HEIGHT'(1);
            end else begin
                cx <= cx + BIT_WIDTH'(1);
            end
            if (cx == screen_width - BIT_WIDTH'(1)) r_n_line <= w_n_line;
            if ((cx == '0) && (cy == '0))           r_n_max  <= w_n_max;
            hsync_out         <= hsync_in;
            vsync_out         <= vsync_in;
            mode              <= w_mode;
            ctrl              <= w_ctrl;
            pkt.packet_enable <= w_in_island && (w_rel[4:0] == 5'(c_isl % PACKET_LEN));
            pkt.island_active <= w_in_island;
        end
    end

endmodule
`default_nettype wire
